friscv_fifo_fwft: RTL and testbench

FRISCV_FIFO_FWFT -- requirements
Module: friscv_fifo_fwft

---
 rtl/friscv_fifo_fwft_pkg.sv | 15 +
 rtl/friscv_scfifo_ram.sv | 27 ++
 rtl/friscv_fifo_fwft.sv | 112 +++++++++++
 tb/tb_friscv_fifo_fwft.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/friscv_fifo_fwft_pkg.sv
// Shared types for the FWFT FIFO: classification of each cycle's push/pop activity.
package friscv_fifo_fwft_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/friscv_scfifo_ram.sv
// Single-clock FIFO storage: registered write port, asynchronous read by address.
module friscv_scfifo_ram #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  aclk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Storage write; contents are intentionally never reset.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/friscv_fifo_fwft.sv
// First-word-fall-through FIFO with level and threshold flags.
// Optional same-cycle bypass into an empty FIFO when FRISCV_FIFO_BYPASS_EN is defined.
module friscv_fifo_fwft
    import friscv_fifo_fwft_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  afull,
    output logic                  aempty
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_LVL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE        = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] ZERO       = {(ADDR_WIDTH+1){1'b0}};

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0] ram_rdata_s;
    logic                  stored_s;
    logic                  byp_s;
    logic                  push_s;
    logic                  pop_s;

    assign stored_s = (level_q != ZERO);

`ifdef FRISCV_FIFO_BYPASS_EN
    assign byp_s = (level_q == ZERO) && in_valid;
`else
    assign byp_s = 1'b0;
`endif

    assign in_ready  = (level_q < DEPTH_LVL);
    assign out_valid = stored_s || byp_s;
    assign out_data  = byp_s    ? in_data     :
                       stored_s ? ram_rdata_s : {DATA_WIDTH{1'b0}};
    assign level     = level_q;
    assign afull     = (level_q >= AFULL_LVL);
    assign aempty    = (level_q <= AEMPTY_LVL);

    // A bypassed word taken by the reader never touches storage.
    assign push_s = in_valid && in_ready && !(byp_s && out_ready);
    assign pop_s  = stored_s && out_ready;

    // Next-state for pointers and level.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case (fifo_op(push_s, pop_s))
            OP_PUSH: level_d = level_q + ONE;
            OP_POP:  level_d = level_q - ONE;
            default: level_d = level_q;
        endcase
    end

    // State registers; synchronous reset wins over any same-cycle handshake.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q <= ZERO;
            rd_ptr_q <= ZERO;
            level_q  <= ZERO;
        end else if (srst) begin
            wr_ptr_q <= ZERO;
            rd_ptr_q <= ZERO;
            level_q  <= ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    friscv_scfifo_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .aclk    (aclk),
        .wr_en   (push_s),
        .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rd_data (ram_rdata_s)
    );

endmodule

// File: tb/tb_friscv_fifo_fwft.sv
// Self-checking bench for friscv_fifo_fwft (DEPTH=4) against a queue-based reference model.
module tb_friscv_fifo_fwft;

    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;
    localparam int AET   = 1;

    logic          aclk;
    logic          aresetn;
    logic          srst;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW:0]   level;
    logic          afull;
    logic          aempty;

    int            checks;
    int            failures;
    logic [DW-1:0] model_q[$];

    friscv_fifo_fwft #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .AFULL_THRESH  (AFT),
        .AEMPTY_THRESH (AET)
    ) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .srst      (srst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .afull     (afull),
        .aempty    (aempty)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle from the negedge, check outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic sr);
        int  n;
        bit  byp;
        bit  exp_valid;
        bit  wr;
        bit  rd;
        logic [DW-1:0] exp_data;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        srst      = sr;
        #1;
        n = model_q.size();
`ifdef FRISCV_FIFO_BYPASS_EN
        byp = (n == 0) && v;
`else
        byp = 1'b0;
`endif
        exp_valid = (n > 0) || byp;
        exp_data  = (n > 0) ? model_q[0] : (byp ? d : 8'h00);
        check_value("out_valid", 32'(out_valid), 32'(exp_valid));
        check_value("out_data",  32'(out_data),  32'(exp_data));
        check_value("level",     32'(level),     32'(n));
        check_value("in_ready",  32'(in_ready),  32'(n < DEPTH));
        check_value("afull",     32'(afull),     32'(n >= AFT));
        check_value("aempty",    32'(aempty),    32'(n <= AET));
        wr = v && (n < DEPTH);
        rd = exp_valid && r;
        @(posedge aclk);
        if (sr) begin
            model_q.delete();
        end else if (byp && r) begin
            // consumed straight through, storage untouched
        end else begin
            if (rd && n > 0) void'(model_q.pop_front());
            if (wr) model_q.push_back(d);
        end
        @(negedge aclk);
        srst = 1'b0;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        aresetn   = 1'b0;
        srst      = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // reset state
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // fill A1..A4 with reader stalled, fifth write refused
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        // drain in order
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // single write into empty FIFO, then observe the following cycle
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // continuous write/read across pointer wrap with level 2
        cycle(1'b1, 8'hB0, 1'b0, 1'b0);
        cycle(1'b1, 8'hB1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'hC0 + 8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // full FIFO with simultaneous write and read
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'hD0 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // srst with level 2 and a concurrent handshake
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'h11, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        cycle(1'b1, 8'h44, 1'b1, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // asynchronous reset in the middle of a transfer
        cycle(1'b1, 8'h66, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        in_valid  = 1'b1;
        in_data   = 8'h88;
        out_ready = 1'b1;
        #2;
        aresetn = 1'b0;
        #1;
        check_value("async_level",  32'(level),     32'd0);
        check_value("async_valid",  32'(out_valid), 32'd0);
        check_value("async_data",   32'(out_data),  32'd0);
        check_value("async_aempty", 32'(aempty),    32'd1);
        check_value("async_afull",  32'(afull),     32'd0);
        model_q.delete();
        @(negedge aclk);
        aresetn = 1'b1;
        cycle(1'b0, 8'h00, 1'b0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 59) == 0));
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
